// File: rtl/puf_eval_controller.sv
// puf_eval_controller: walks challenge-selected RO pairs, compares their counts,
// and packs the resulting bits MSB-first into bytes pushed to the response FIFO.
module puf_eval_controller #(
    parameter int RESP_WORDS    = 4,
    parameter int SEL_BITS      = 5,
    parameter int CNT_W         = 16,
    parameter int EVAL_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          challenge,
    output logic                done,
    output logic                busy,
    output logic [SEL_BITS-1:0] ro_sel,
    output logic                ro_enable,
    output logic                cnt_clear,
    input  logic [CNT_W-1:0]    cnt_a,
    input  logic [CNT_W-1:0]    cnt_b,
    output logic                fifo_we,
    output logic [7:0]          fifo_din,
    input  logic                fifo_full
);
    localparam int NBITS = RESP_WORDS * 8;
    localparam int BW    = $clog2(NBITS);
    localparam int TMAX  = EVAL_CYCLES > SETTLE_CYCLES ? EVAL_CYCLES : SETTLE_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, COMPARE, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic                enable_q;
    logic [7:0]          chal_q, chal_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [7:0]          sr_q, sr_d;
    logic [SEL_BITS-1:0] ro_sel_q, ro_sel_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            enable_q  <= 1'b0;
            chal_q    <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            sr_q      <= '0;
            ro_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable;
            chal_q    <= chal_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            sr_q      <= sr_d;
            ro_sel_q  <= ro_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        chal_d    = chal_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        sr_d      = sr_q;
        case (state_q)
            IDLE: if (enable && !enable_q) begin
                state_d   = CLEAR;
                chal_d    = challenge;
                bit_cnt_d = '0;
                sr_d      = '0;
            end
            CLEAR: begin
                state_d = RUN;
                timer_d = '0;
            end
            RUN: if (timer_q == TW'(EVAL_CYCLES - 1)) begin
                state_d = SETTLE;
                timer_d = '0;
            end else timer_d = timer_q + 1'b1;
            SETTLE: if (timer_q == TW'(SETTLE_CYCLES - 1)) state_d = COMPARE;
                    else timer_d = timer_q + 1'b1;
            COMPARE: begin
                sr_d[3'd7 - bit_cnt_q[2:0]] = cnt_a > cnt_b;
                if (&bit_cnt_q[2:0]) state_d = WRITE;
                else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = CLEAR;
                end
            end
            WRITE: if (!fifo_full) begin
                if (bit_cnt_q == BW'(NBITS - 1)) state_d = DONE;
                else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = CLEAR;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort wins over every in-flight transition, including a pending write
        if (!enable && state_q != IDLE && state_q != DONE) state_d = IDLE;
        ro_sel_d = (state_d == CLEAR && state_q != CLEAR) ?
                   SEL_BITS'(32'(chal_d) + 32'(bit_cnt_d)) : ro_sel_q;
    end

    always_comb begin
        done      = !reset && state_q == DONE;
        busy      = !reset && state_q != IDLE;
        cnt_clear = !reset && state_q == CLEAR;
        ro_enable = !reset && state_q == RUN;
        fifo_we   = !reset && state_q == WRITE && !fifo_full && enable;
        fifo_din  = (!reset && state_q == WRITE) ? sr_q : 8'h00;
        ro_sel    = busy ? ro_sel_q : '0;
    end
endmodule

// File: tb/tb_puf_eval_controller.sv
// tb_puf_eval_controller: directed evaluations checked every cycle against a phase-offset model.
module tb_puf_eval_controller;
    localparam int RW     = 2;
    localparam int EVAL   = 8;
    localparam int SETTLE = 2;
    localparam int BITLEN = EVAL + SETTLE + 2;
    localparam int BYTLEN = 8 * BITLEN + 1;
    localparam int NTOT   = RW * BYTLEN;

    logic        clk = 0;
    logic        reset = 1;
    logic        enable = 0;
    logic [7:0]  challenge = 0;
    logic        done, busy, ro_enable, cnt_clear, fifo_we, fifo_full = 0;
    logic [4:0]  ro_sel;
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  fifo_din;
    logic        tie = 0;
    logic [31:0] pat = 32'h0000_02A8;

    int errors = 0, checks = 0, cyc = 0, n_done = 0;
    int wr_q[$];
    int sel_q[$];

    puf_eval_controller #(.RESP_WORDS(RW), .SEL_BITS(5), .CNT_W(16),
        .EVAL_CYCLES(EVAL), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .enable(enable), .challenge(challenge),
        .done(done), .busy(busy), .ro_sel(ro_sel), .ro_enable(ro_enable),
        .cnt_clear(cnt_clear), .cnt_a(cnt_a), .cnt_b(cnt_b), .fifo_we(fifo_we),
        .fifo_din(fifo_din), .fifo_full(fifo_full));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cnt_a = tie ? 16'h0100 : (pat[ro_sel] ? 16'd500 : 16'd300);
    assign cnt_b = tie ? 16'h0100 : (pat[ro_sel] ? 16'd300 : 16'd500);

    wire [17:0] vec = {done, busy, ro_sel, ro_enable, cnt_clear, fifo_we, fifo_din};

    function automatic int pair(int ch, int idx);
        return (ch + idx) % 32;
    endfunction

    function automatic int exp_byte(int ch, int b);
        int v = 0;
        for (int j = 0; j < 8; j++) v = v * 2 + ((!tie && pat[pair(ch, b * 8 + j)]) ? 1 : 0);
        return v;
    endfunction

    function automatic logic [17:0] pack(bit d, bit b, int s, bit re, bit cc, bit we, int din);
        return {d, b, 5'(s), re, cc, we, 8'(din)};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // model: position m_p within the evaluation timeline, frozen while a write stalls
    bit m_act = 0, m_prev = 0;
    int m_p = 0, m_chal = 0;
    always @(negedge clk) begin
        logic [17:0] e;
        int byt, r, q;
        e = '0;
        if (reset) begin
            m_act = 0;
            m_prev = 0;
        end else begin
            if (m_act) begin
                if (m_p == NTOT) begin
                    e = pack(1, 1, pair(m_chal, RW * 8 - 1), 0, 0, 0, 0);
                    m_act = 0;
                end else begin
                    byt = m_p / BYTLEN;
                    r = m_p % BYTLEN;
                    if (r == BYTLEN - 1) begin
                        e = pack(0, 1, pair(m_chal, byt * 8 + 7), 0, 0, !fifo_full && enable,
                                 exp_byte(m_chal, byt));
                        if (!enable) m_act = 0;
                        else if (!fifo_full) m_p++;
                    end else begin
                        q = r % BITLEN;
                        e = pack(0, 1, pair(m_chal, byt * 8 + r / BITLEN), q >= 1 && q <= EVAL,
                                 q == 0, 0, 0);
                        if (!enable) m_act = 0;
                        else m_p++;
                    end
                end
            end else if (enable && !m_prev) begin
                m_act = 1;
                m_p = 0;
                m_chal = challenge;
            end
            m_prev = enable;
        end
        checks++;
        if (vec !== e) begin
            errors++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, vec, e);
        end
    end

    always @(negedge clk) begin
        if (fifo_we) wr_q.push_back(fifo_din);
        if (cnt_clear) sel_q.push_back(ro_sel);
        if (done) n_done++;
    end

    // called just after a posedge; returns just after a posedge
    task automatic run_eval(int ch, bit tie_i, int stall, int hold, int e0, int e1);
        int s, d, bz;
        bit got;
        wr_q.delete();
        sel_q.delete();
        n_done = 0;
        got = 0;
        d = 0;
        bz = 0;
        tie = tie_i;
        challenge = 8'(ch);
        fifo_full = stall > 0;
        enable = 1;
        @(negedge clk);
        @(negedge clk);
        s = cyc;
        challenge = 8'hFF;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk);
            #1 fifo_full = stall > 0 && (cyc - s) < BYTLEN - 1 + stall;
            @(negedge clk);
            if (done) begin
                got = 1;
                d = cyc;
            end
        end
        chk("done_seen", got, 1);
        chk("latency", d - s, NTOT + stall);
        repeat (hold) begin
            @(negedge clk);
            if (busy) bz++;
        end
        chk("no_retrigger", bz, 0);
        @(posedge clk);
        #1 enable = 0;
        fifo_full = 0;
        repeat (2) @(negedge clk);
        chk("done_count", n_done, 1);
        chk("write_count", wr_q.size(), 2);
        chk("byte0", wr_q.size() > 0 ? wr_q[0] : -1, e0);
        chk("byte1", wr_q.size() > 1 ? wr_q[1] : -1, e1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s, exp_sel[8];
        exp_sel = '{30, 31, 0, 1, 2, 3, 4, 5};
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("after_reset", int'(vec), 0);
        @(posedge clk);
        #1;
        run_eval(8'h03, 0, 0, 0, 8'hAA, 8'h00);
        run_eval(8'h1E, 0, 0, 0, 8'h05, 8'h50);
        for (int i = 0; i < 8; i++)
            chk("wrap_sel", sel_q.size() > i ? sel_q[i] : -1, exp_sel[i]);
        run_eval(8'h07, 1, 0, 0, 8'h00, 8'h00);
        run_eval(8'h03, 0, 20, 0, 8'hAA, 8'h00);
        // abort during RUN of bit 5
        wr_q.delete();
        n_done = 0;
        challenge = 8'h03;
        enable = 1;
        @(negedge clk);
        @(negedge clk);
        repeat (5 * BITLEN + 3) @(posedge clk);
        #1 enable = 0;
        @(negedge clk);
        chk("abort_run_last", int'(ro_enable), 1);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ro_enable", int'(ro_enable), 0);
        repeat (20) @(negedge clk);
        chk("abort_writes", wr_q.size(), 0);
        chk("abort_done", n_done, 0);
        @(posedge clk);
        #1;
        run_eval(8'h03, 0, 0, 50, 8'hAA, 8'h00);
        // reset during SETTLE of bit 2
        challenge = 8'h03;
        enable = 1;
        @(negedge clk);
        @(negedge clk);
        s = cyc;
        repeat (2 * BITLEN + EVAL + 1) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("reset_pos", cyc - s, 2 * BITLEN + EVAL + 1);
        chk("in_reset", int'(vec), 0);
        @(posedge clk);
        #1 reset = 0;
        enable = 0;
        @(negedge clk);
        chk("post_reset", int'(vec), 0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
